// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the imem/dmem memory-port arbiter.
package mem_arb_pkg;

    localparam int unsigned TYP_W = 3;

    localparam logic             M_XRD = 1'b0;
    localparam logic             M_XWR = 1'b1;
    localparam logic [TYP_W-1:0] MT_W  = 3'd3;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of data grants won while an instruction fetch was waiting.
module mem_arb_starve_cnt #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [3:0] MAX = 4'(MAX_WAIT);

    logic [3:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != MAX)) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign sat = (cnt_q == MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one backing memory port between instruction fetch and data access,
// one transaction outstanding at a time.
//   state | meaning
//   IDLE  | no transaction; grant chosen combinationally, can complete this cycle
//   REQ   | grant latched in owner_q, waiting for mreq_ready
//   RESP  | request accepted, waiting for mresp_valid to route back to owner
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ireq_valid,
    output logic              ireq_ready,
    input  logic [ADDR_W-1:0] ireq_addr,
    output logic              iresp_valid,
    output logic [DATA_W-1:0] iresp_data,
    input  logic              dreq_valid,
    output logic              dreq_ready,
    input  logic [ADDR_W-1:0] dreq_addr,
    input  logic              dreq_fcn,
    input  logic [TYP_W-1:0]  dreq_typ,
    input  logic [DATA_W-1:0] dreq_wdata,
    output logic              dresp_valid,
    output logic [DATA_W-1:0] dresp_data,
    output logic              mreq_valid,
    input  logic              mreq_ready,
    output logic [ADDR_W-1:0] mreq_addr,
    output logic              mreq_fcn,
    output logic [TYP_W-1:0]  mreq_typ,
    output logic [DATA_W-1:0] mreq_wdata,
    input  logic              mresp_valid,
    input  logic [DATA_W-1:0] mresp_data,
    output logic              err
);

    state_t state_q, state_d;
    owner_t owner_q, owner_d;
    owner_t sel;
    logic   hs;
    logic   sat;
    logic   err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            if (mresp_valid && (state_q != RESP)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Outputs are masked while rst is low so nothing leaks out during reset.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        sel         = owner_q;
        mreq_valid  = 1'b0;
        hs          = 1'b0;
        ireq_ready  = 1'b0;
        dreq_ready  = 1'b0;
        iresp_valid = 1'b0;
        dresp_valid = 1'b0;
        iresp_data  = '0;
        dresp_data  = '0;
        if (rst) begin
            unique case (state_q)
                IDLE: begin
                    if (ireq_valid || dreq_valid) begin
                        sel        = (dreq_valid && !(ireq_valid && sat)) ? OWN_D : OWN_I;
                        owner_d    = sel;
                        mreq_valid = 1'b1;
                        state_d    = mreq_ready ? RESP : REQ;
                    end
                end
                REQ: begin
                    mreq_valid = 1'b1;
                    if (mreq_ready) begin
                        state_d = RESP;
                    end
                end
                RESP: begin
                    if (mresp_valid) begin
                        state_d = IDLE;
                        if (owner_q == OWN_D) begin
                            dresp_valid = 1'b1;
                            dresp_data  = mresp_data;
                        end else begin
                            iresp_valid = 1'b1;
                            iresp_data  = mresp_data;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
            hs         = mreq_valid && mreq_ready;
            ireq_ready = hs && (sel == OWN_I);
            dreq_ready = hs && (sel == OWN_D);
        end
    end

    // Instruction grants always look like word reads on the backing port.
    always_comb begin
        mreq_addr  = '0;
        mreq_fcn   = M_XRD;
        mreq_typ   = '0;
        mreq_wdata = '0;
        if (mreq_valid) begin
            if (sel == OWN_D) begin
                mreq_addr  = dreq_addr;
                mreq_fcn   = dreq_fcn;
                mreq_typ   = dreq_typ;
                mreq_wdata = dreq_wdata;
            end else begin
                mreq_addr = ireq_addr;
                mreq_typ  = MT_W;
            end
        end
    end

    mem_arb_starve_cnt #(
        .MAX_WAIT(MAX_WAIT)
    ) u_starve (
        .clk(clk),
        .rst(rst),
        .inc(dreq_ready && ireq_valid),
        .clr(ireq_ready),
        .sat(sat)
    );

    assign err = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: responses go through an expectation queue
// drained by an independent monitor; request-side fields are checked inline.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ireq_valid, ireq_ready;
    logic [31:0] ireq_addr;
    logic        iresp_valid;
    logic [31:0] iresp_data;
    logic        dreq_valid, dreq_ready;
    logic [31:0] dreq_addr;
    logic        dreq_fcn;
    logic [2:0]  dreq_typ;
    logic [31:0] dreq_wdata;
    logic        dresp_valid;
    logic [31:0] dresp_data;
    logic        mreq_valid, mreq_ready;
    logic [31:0] mreq_addr;
    logic        mreq_fcn;
    logic [2:0]  mreq_typ;
    logic [31:0] mreq_wdata;
    logic        mresp_valid;
    logic [31:0] mresp_data;
    logic        err;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .ireq_valid(ireq_valid), .ireq_ready(ireq_ready), .ireq_addr(ireq_addr),
        .iresp_valid(iresp_valid), .iresp_data(iresp_data),
        .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_addr(dreq_addr),
        .dreq_fcn(dreq_fcn), .dreq_typ(dreq_typ), .dreq_wdata(dreq_wdata),
        .dresp_valid(dresp_valid), .dresp_data(dresp_data),
        .mreq_valid(mreq_valid), .mreq_ready(mreq_ready), .mreq_addr(mreq_addr),
        .mreq_fcn(mreq_fcn), .mreq_typ(mreq_typ), .mreq_wdata(mreq_wdata),
        .mresp_valid(mresp_valid), .mresp_data(mresp_data),
        .err(err)
    );

    typedef struct packed {
        logic        own_d;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t expq[$];
    int   vecs = 0;
    int   errs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_resp(input logic own_d, input logic chk_data, input logic [31:0] data);
        exp_t e;
        e.own_d    = own_d;
        e.chk_data = chk_data;
        e.data     = data;
        expq.push_back(e);
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every resp_valid must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (iresp_valid || dresp_valid) begin
            vecs++;
            if (iresp_valid && dresp_valid) begin
                errs++;
                $display("FAIL resp_both: iresp_valid=1 dresp_valid=1 expected one");
            end else if (expq.size() == 0) begin
                errs++;
                $display("FAIL resp_unexpected: iresp_valid=%0b dresp_valid=%0b expected none",
                         iresp_valid, dresp_valid);
            end else begin
                e = expq.pop_front();
                if (e.own_d !== dresp_valid) begin
                    errs++;
                    $display("FAIL resp_owner: dresp_valid=%0b expected own_d=%0b", dresp_valid, e.own_d);
                end else if (e.chk_data && ((dresp_valid ? dresp_data : iresp_data) !== e.data)) begin
                    errs++;
                    $display("FAIL resp_data: got %h expected %h",
                             dresp_valid ? dresp_data : iresp_data, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_d;
        rst = 1'b0;
        ireq_valid = 1'b1; ireq_addr = 32'h0;
        dreq_valid = 1'b0; dreq_addr = 32'h0; dreq_fcn = 1'b0; dreq_typ = 3'd0; dreq_wdata = 32'h0;
        mreq_ready = 1'b1; mresp_valid = 1'b0; mresp_data = 32'h0;

        // Reset: outputs quiet even with a requester and memory ready
        mid();
        chk("rst_mreq_valid", mreq_valid, 0);
        chk("rst_ireq_ready", ireq_ready, 0);
        chk("rst_err", err, 0);
        chk("rst_mreq_addr", mreq_addr, 0);
        ireq_valid = 1'b0; mreq_ready = 1'b0;
        nxt();
        rst = 1'b1;
        nxt();

        // Lone fetch; dmem fields carry junk that must not leak onto the port
        ireq_valid = 1'b1; ireq_addr = 32'h100; mreq_ready = 1'b1;
        dreq_fcn = 1'b1; dreq_typ = 3'd2; dreq_wdata = 32'hFFFF_FFFF; dreq_addr = 32'hAAAA_0000;
        mid();
        chk("fetch_ireq_ready", ireq_ready, 1);
        chk("fetch_dreq_ready", dreq_ready, 0);
        chk("fetch_mreq_valid", mreq_valid, 1);
        chk("fetch_mreq_addr", mreq_addr, 32'h100);
        chk("fetch_mreq_fcn", mreq_fcn, 0);
        chk("fetch_mreq_typ", mreq_typ, 3);
        chk("fetch_mreq_wdata", mreq_wdata, 0);
        nxt();
        ireq_valid = 1'b0; mreq_ready = 1'b0;
        mid();
        chk("fetch_wait_mreq_valid", mreq_valid, 0);
        nxt();
        mresp_valid = 1'b1; mresp_data = 32'h0000_0013;
        expect_resp(1'b0, 1'b1, 32'h0000_0013);
        mid();
        chk("fetch_iresp_valid", iresp_valid, 1);
        nxt();
        mresp_valid = 1'b0;
        chk("fetch_drained", expq.size(), 0);
        dreq_fcn = 1'b0; dreq_typ = 3'd3; dreq_wdata = 32'h0;

        // Contention with zero-wait memory: D,D,D,D,I repeating
        for (int k = 0; k < 10; k++) begin
            exp_d = ((k % 5) != 4);
            ireq_valid = 1'b1; ireq_addr = 32'h1000 + 32'(k * 4);
            dreq_valid = 1'b1; dreq_addr = 32'h8000 + 32'(k * 4);
            mreq_ready = 1'b1; mresp_valid = 1'b0;
            mid();
            chk($sformatf("cont%0d_dreq_ready", k), dreq_ready, exp_d);
            chk($sformatf("cont%0d_ireq_ready", k), ireq_ready, !exp_d);
            chk($sformatf("cont%0d_mreq_addr", k), mreq_addr,
                exp_d ? 32'h8000 + 32'(k * 4) : 32'h1000 + 32'(k * 4));
            nxt();
            mreq_ready = 1'b0; mresp_valid = 1'b1; mresp_data = 32'hA000_0000 + 32'(k);
            expect_resp(exp_d, 1'b1, 32'hA000_0000 + 32'(k));
            mid();
            chk($sformatf("cont%0d_resp_rdy", k), {31'b0, ireq_ready | dreq_ready}, 0);
            chk($sformatf("cont%0d_resp_mvalid", k), mreq_valid, 0);
            nxt();
        end
        ireq_valid = 1'b0; dreq_valid = 1'b0; mresp_valid = 1'b0;
        chk("cont_drained", expq.size(), 0);
        nxt();

        // Grant hold: imem stalled, dmem arrives; grant must not move
        ireq_valid = 1'b1; ireq_addr = 32'h200; mreq_ready = 1'b0;
        mid();
        chk("hold0_mreq_addr", mreq_addr, 32'h200);
        chk("hold0_ireq_ready", ireq_ready, 0);
        nxt();
        dreq_valid = 1'b1; dreq_addr = 32'h3000; dreq_fcn = 1'b0;
        for (int c = 1; c < 3; c++) begin
            mid();
            chk($sformatf("hold%0d_mreq_addr", c), mreq_addr, 32'h200);
            chk($sformatf("hold%0d_dreq_ready", c), dreq_ready, 0);
            chk($sformatf("hold%0d_mreq_valid", c), mreq_valid, 1);
            nxt();
        end
        mreq_ready = 1'b1;
        mid();
        chk("hold3_ireq_ready", ireq_ready, 1);
        chk("hold3_dreq_ready", dreq_ready, 0);
        chk("hold3_mreq_addr", mreq_addr, 32'h200);
        nxt();
        ireq_valid = 1'b0; mreq_ready = 1'b0; mresp_valid = 1'b1; mresp_data = 32'h55;
        expect_resp(1'b0, 1'b1, 32'h55);
        mid();
        chk("hold_resp_dreq_ready", dreq_ready, 0);
        nxt();
        mresp_valid = 1'b0; mreq_ready = 1'b1;
        mid();
        chk("hold_d_dreq_ready", dreq_ready, 1);
        chk("hold_d_mreq_addr", mreq_addr, 32'h3000);
        nxt();
        dreq_valid = 1'b0; mreq_ready = 1'b0; mresp_valid = 1'b1; mresp_data = 32'h66;
        expect_resp(1'b1, 1'b1, 32'h66);
        nxt();
        mresp_valid = 1'b0;
        chk("hold_drained", expq.size(), 0);

        // Store acknowledge
        dreq_valid = 1'b1; dreq_addr = 32'h2000; dreq_fcn = 1'b1; dreq_typ = 3'd2;
        dreq_wdata = 32'hDEAD_BEEF; mreq_ready = 1'b1;
        mid();
        chk("st_dreq_ready", dreq_ready, 1);
        chk("st_mreq_fcn", mreq_fcn, 1);
        chk("st_mreq_addr", mreq_addr, 32'h2000);
        chk("st_mreq_typ", mreq_typ, 2);
        chk("st_mreq_wdata", mreq_wdata, 32'hDEAD_BEEF);
        nxt();
        dreq_valid = 1'b0; mreq_ready = 1'b0;
        nxt();
        mresp_valid = 1'b1; mresp_data = 32'h0;
        expect_resp(1'b1, 1'b0, 32'h0);
        mid();
        chk("st_ack_dresp_valid", dresp_valid, 1);
        nxt();
        mresp_valid = 1'b0; dreq_fcn = 1'b0;
        chk("st_drained", expq.size(), 0);

        // Spurious response in IDLE
        mresp_valid = 1'b1; mresp_data = 32'h77;
        mid();
        chk("spur_err_before", err, 0);
        nxt();
        mresp_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mid();
            chk($sformatf("spur_err_sticky%0d", c), err, 1);
            nxt();
        end
        rst = 1'b0;
        mid();
        chk("spur_err_cleared", err, 0);
        nxt();
        rst = 1'b1;
        nxt();

        // Reset while in RESP, then a stale response
        ireq_valid = 1'b1; ireq_addr = 32'h400; mreq_ready = 1'b1;
        mid();
        chk("rr_ireq_ready", ireq_ready, 1);
        nxt();
        ireq_valid = 1'b0; mreq_ready = 1'b0; rst = 1'b0;
        nxt();
        rst = 1'b1; mresp_valid = 1'b1; mresp_data = 32'h99;
        mid();
        chk("rr_stale_iresp", iresp_valid, 0);
        nxt();
        mresp_valid = 1'b0;
        mid();
        chk("rr_err", err, 1);
        nxt();
        ireq_valid = 1'b1; ireq_addr = 32'h500; mreq_ready = 1'b1;
        mid();
        chk("rr_next_ireq_ready", ireq_ready, 1);
        chk("rr_next_mreq_addr", mreq_addr, 32'h500);
        nxt();
        ireq_valid = 1'b0; mreq_ready = 1'b0; mresp_valid = 1'b1; mresp_data = 32'h1234_5678;
        expect_resp(1'b0, 1'b1, 32'h1234_5678);
        nxt();
        mresp_valid = 1'b0;
        nxt();

        chk("final_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single backing memory port between the instruction-fetch requester and the data requester of the 1-stage RV32 core. Sits between the core's imem/dmem ports and the memory/HTIF side. It accepts one request at a time, holds the grant stable until the backing port accepts it, then waits for the response and routes it back to the owner. Data requests win by default; a saturating starvation counter forces an instruction grant after a bounded number of data wins.

## Interface

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_WAIT, 4, consecutive data grants with ireq pending before imem is forced; range 1..15

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- ireq_valid  in  1  instruction request valid
- ireq_ready  out  1  instruction request accepted this cycle
- ireq_addr  in  ADDR_W  instruction fetch address
- iresp_valid  out  1  instruction response valid
- iresp_data  out  DATA_W  instruction word
- dreq_valid  in  1  data request valid
- dreq_ready  out  1  data request accepted this cycle
- dreq_addr  in  ADDR_W  data address
- dreq_fcn  in  1  0 = read (M_XRD), 1 = write (M_XWR)
- dreq_typ  in  3  access size/sign code, passed through unchanged
- dreq_wdata  in  DATA_W  store data
- dresp_valid  out  1  data response or write acknowledge
- dresp_data  out  DATA_W  load data; undefined on write acknowledge
- mreq_valid  out  1  backing-port request valid
- mreq_ready  in  1  backing port accepts request
- mreq_addr, mreq_fcn, mreq_typ, mreq_wdata  out  ADDR_W/1/3/DATA_W  muxed request fields; imem forces fcn = M_XRD, typ = word, wdata = 0
- mresp_valid  in  1  backing-port response valid
- mresp_data  in  DATA_W  backing-port response data
- err  out  1  sticky: mresp_valid received while no transaction is outstanding

## Operation

- FSM states: IDLE, REQ, RESP. Owner register: OWN_I or OWN_D.
- IDLE:
  - If neither valid is asserted, mreq_valid = 0.
  - Otherwise select the owner combinationally: data if dreq_valid and not (ireq_valid and starve == MAX_WAIT); else instruction.
  - Drive the selected fields and assert mreq_valid.
  - If mreq_ready is asserted, the handshake completes: owner ready = 1 and the FSM goes to RESP.
  - If mreq_ready is not asserted, latch the owner and go to REQ.
- REQ:
  - Drive the latched owner's fields with mreq_valid = 1. The grant does not change even if the other requester raises valid.
  - On mreq_ready: owner ready = 1, go to RESP.
- RESP:
  - mreq_valid = 0; both ready outputs = 0.
  - On mresp_valid, pass through combinationally to the owner (owner resp_valid = 1, resp_data = mresp_data) and go to IDLE.
  - Writes also wait for mresp_valid, which acts as the acknowledge.
- Starvation counter, 4 bits, saturating at MAX_WAIT:
  - Increments on a data handshake while ireq_valid = 1.
  - Clears on an instruction handshake.
  - Otherwise holds.
- err: set when mresp_valid = 1 in IDLE or REQ; cleared only by reset. A spurious response is never routed to either requester.
- Requesters follow valid/ready rules: fields stay stable while valid is high and ready is low.

## Timing

- Reset values: state = IDLE, owner = OWN_I, starve = 0, err = 0. All ready, resp_valid and mreq_valid outputs = 0 during reset. Data outputs = 0.
- Reset mid-transaction: the outstanding transaction is dropped with no response delivered. A late mresp_valid after reset sets err.
- Request path is combinational (zero latency): if mreq_ready is high, the request is accepted in the same cycle requester valid rises.
- Response path is combinational: resp_valid appears in the same cycle as mresp_valid.
- One transaction outstanding at a time. The earliest next grant is the cycle after the response, so peak throughput is one transaction per 2 cycles when memory has zero wait states.
- mresp_valid in the same cycle as the handshake is illegal for the backing port; it sets err.
- Simultaneous ireq_valid and dreq_valid in IDLE with starve < MAX_WAIT: data wins and starve increments.

## Structure

- Shared package mem_arb_pkg: state enum {IDLE, REQ, RESP}, owner enum {OWN_I, OWN_D}, M_XRD/M_XWR constants, MT_W word typ code, typ width.
- One sub-module, mem_arb_starve_cnt: saturating counter with inc, clr, and sat (== MAX_WAIT) outputs.
- Top level contains the FSM, the owner register, the muxes and err.

## Test plan

- Lone fetch: ireq_valid = 1, addr 0x100, mreq_ready = 1, mresp 2 cycles later with 0x00000013. Expect ireq_ready in cycle 0, iresp_valid and data 0x13 in cycle 2, dresp_valid = 0 throughout.
- Contention: both valid every cycle, MAX_WAIT = 4, zero-wait memory. Expect grant sequence D,D,D,D,I repeating, with the counter clearing after each I.
- Grant hold: ireq_valid with mreq_ready = 0 for 3 cycles, dreq_valid rising in cycle 1. Expect mreq_addr to stay the imem address and dreq_ready = 0 until the imem handshake completes.
- Store ack: dreq write, addr 0x2000, wdata 0xDEADBEEF. Expect mreq_fcn = 1, mreq_wdata passed through, and dresp_valid exactly in the mresp_valid cycle.
- Spurious response: mresp_valid in IDLE. Expect err = 1, sticky, with no resp_valid on either side; assert rst low and expect err = 0.
- Reset in RESP: rst low for 1 cycle, then stale mresp_valid. Expect no resp_valid, err = 1, and the next ireq granted normally.
